// File: rtl/prim_filter_ctr_multi.sv
// Multi-channel counter-based glitch filter with a shared stable-count threshold,
// per-channel enables, an optional input synchronizer and rise/fall event pulses.

module prim_filter_ctr_ch #(
    parameter int unsigned CtrWidth   = 4,
    parameter bit          AsyncOn    = 1'b1,
    parameter logic        ResetValue = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [CtrWidth-1:0] thresh_i,
    input  logic                filter_i,
    output logic                filter_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic                in_s;
    logic                prev_q;
    logic                stored_q;
    logic                rise_q;
    logic                fall_q;
    logic [CtrWidth-1:0] ctr_q;
    logic [CtrWidth-1:0] ctr_d;
    logic                update;

    if (AsyncOn) begin : g_sync
        logic [1:0] sync_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) sync_q <= {2{ResetValue}};
            else         sync_q <= {sync_q[0], filter_i};
        end
        assign in_s = sync_q[1];
    end else begin : g_nosync
        assign in_s = filter_i;
    end

    // Counter saturates at the threshold, so it can never wrap.
    always_comb begin
        ctr_d = ctr_q;
        if (in_s != prev_q)         ctr_d = '0;
        else if (ctr_q >= thresh_i) ctr_d = ctr_q;
        else                        ctr_d = ctr_q + CtrWidth'(1);
    end

    assign update = (ctr_d >= thresh_i);

    // Filter state runs regardless of enable so enabling shows a settled value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q   <= ResetValue;
            stored_q <= ResetValue;
            ctr_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            prev_q <= in_s;
            ctr_q  <= ctr_d;
            if (update) stored_q <= in_s;
            rise_q <= enable_i & update &  in_s & ~stored_q;
            fall_q <= enable_i & update & ~in_s &  stored_q;
        end
    end

    assign filter_o = enable_i ? stored_q : in_s;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

module prim_filter_ctr_multi #(
    parameter int unsigned NumCh      = 8,
    parameter int unsigned CtrWidth   = 4,
    parameter bit          AsyncOn    = 1'b1,
    parameter logic        ResetValue = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumCh-1:0]    enable_i,
    input  logic [CtrWidth-1:0] thresh_i,
    input  logic [NumCh-1:0]    filter_i,
    output logic [NumCh-1:0]    filter_o,
    output logic [NumCh-1:0]    rise_o,
    output logic [NumCh-1:0]    fall_o
);

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        prim_filter_ctr_ch #(
            .CtrWidth  (CtrWidth),
            .AsyncOn   (AsyncOn),
            .ResetValue(ResetValue)
        ) u_ch (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .enable_i(enable_i[c]),
            .thresh_i(thresh_i),
            .filter_i(filter_i[c]),
            .filter_o(filter_o[c]),
            .rise_o  (rise_o[c]),
            .fall_o  (fall_o[c])
        );
    end

endmodule

// File: tb/tb_prim_filter_ctr_multi.sv
// Directed bench for prim_filter_ctr_multi: one instance without and one with
// the input synchronizer, driven from shared inputs.

module tb_prim_filter_ctr_multi;

    logic       clk_i;
    logic       rst_ni;
    logic [7:0] enable_i;
    logic [3:0] thresh_i;
    logic [7:0] filter_i;
    logic [7:0] fo0, ro0, fa0;
    logic [7:0] fo1, ro1, fa1;

    int n_chk = 0;
    int n_err = 0;

    prim_filter_ctr_multi #(.NumCh(8), .CtrWidth(4), .AsyncOn(1'b0), .ResetValue(1'b0)) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .thresh_i(thresh_i),
        .filter_i(filter_i), .filter_o(fo0), .rise_o(ro0), .fall_o(fa0)
    );

    prim_filter_ctr_multi #(.NumCh(8), .CtrWidth(4), .AsyncOn(1'b1), .ResetValue(1'b0)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .thresh_i(thresh_i),
        .filter_i(filter_i), .filter_o(fo1), .rise_o(ro1), .fall_o(fa1)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; returns 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic       pv;
        logic       seen;

        rst_ni   = 1'b0;
        enable_i = 8'hFF;
        thresh_i = 4'd3;
        filter_i = 8'h00;
        tick(2);
        chk("rst_filter0", fo0, 8'h00);
        chk("rst_rise0", ro0, 8'h00);
        chk("rst_fall0", fa0, 8'h00);
        chk("rst_filter1", fo1, 8'h00);
        rst_ni = 1'b1;
        tick(5);

        // 1: T=3 edge on ch0 shows after 4 edges with a single rise pulse
        filter_i[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk($sformatf("t1_filt_%0d", i), fo0[0], (i == 4));
            chk($sformatf("t1_rise_%0d", i), ro0[0], (i == 4));
        end
        tick(1);
        chk("t1_rise_end", ro0[0], 1'b0);
        chk("t1_filt_hold", fo0[0], 1'b1);

        filter_i[0] = 1'b0;
        tick(3);
        chk("t1_fall_early", fa0[0], 1'b0);
        tick(1);
        chk("t1_fall", fa0[0], 1'b1);
        chk("t1_filt_low", fo0[0], 1'b0);
        tick(6);

        // 2: 3-cycle glitch is rejected
        seen = 1'b0;
        filter_i[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) filter_i[0] = 1'b0;
            tick(1);
            if (fo0[0] || ro0[0] || fa0[0]) seen = 1'b1;
        end
        chk("t2_glitch", seen, 1'b0);

        // 3: T=0 is a plain register with events on every edge
        thresh_i = 4'd0;
        tick(1);
        pat = 8'b1011_0010;
        pv  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            filter_i[5] = pat[i];
            tick(1);
            chk($sformatf("t3_filt_%0d", i), fo0[5], pat[i]);
            chk($sformatf("t3_rise_%0d", i), ro0[5], pat[i] & ~pv);
            chk($sformatf("t3_fall_%0d", i), fa0[5], ~pat[i] & pv);
            pv = pat[i];
        end
        filter_i[5] = 1'b0;
        tick(1);

        // 4: disabled channel passes raw input, enabling shows settled value, no event
        thresh_i    = 4'd3;
        enable_i[1] = 1'b0;
        filter_i[1] = 1'b1;
        seen = 1'b0;
        tick(1);
        chk("t4_raw", fo0[1], 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (ro0[1]) seen = 1'b1;
        end
        enable_i[1] = 1'b1;
        #1;
        chk("t4_enable_val", fo0[1], 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (ro0[1]) seen = 1'b1;
        end
        chk("t4_no_rise", seen, 1'b0);

        // 5: synchronized channel, T=2, changes 5 edges after input edge
        thresh_i    = 4'd2;
        tick(2);
        filter_i[2] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk($sformatf("t5_filt_%0d", i), fo1[2], (i == 5));
            chk($sformatf("t5_rise_%0d", i), ro1[2], (i == 5));
        end

        // 5b: lower threshold below a count of 5 with stable input
        thresh_i    = 4'd15;
        tick(1);
        filter_i[6] = 1'b1;
        tick(6);
        chk("t5b_before", fo0[6], 1'b0);
        thresh_i = 4'd1;
        tick(1);
        chk("t5b_filt", fo0[6], 1'b1);
        chk("t5b_rise", ro0[6], 1'b1);

        // 6: reset mid-count, then ch3 toggling while ch4 held
        thresh_i    = 4'd3;
        filter_i[3] = 1'b1;
        tick(2);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_filt0", fo0, 8'h00);
        chk("t6_rst_rise0", ro0, 8'h00);
        chk("t6_rst_fall0", fa0, 8'h00);
        chk("t6_rst_filt1", fo1, 8'h00);
        filter_i = 8'h00;
        tick(1);
        rst_ni = 1'b1;
        filter_i[4] = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            filter_i[3] = ~filter_i[3];
            tick(1);
            if (fo0[3] || ro0[3] || fa0[3]) seen = 1'b1;
            chk($sformatf("t6_filt4_%0d", i), fo0[4], (i >= 4));
            chk($sformatf("t6_rise4_%0d", i), ro0[4], (i == 4));
        end
        chk("t6_ch3_quiet", seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
